mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4, meaning the maximum consecutive grants to one master while the other master is requesting (legal range 1..255).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 SHALL have, for N in {0,1}, port i_mN_req  input  1  master N requests an access this cycle.
REQ-005 SHALL have, for N in {0,1}, port i_mN_addr  input  30  word address.
REQ-006 SHALL have, for N in {0,1}, port i_mN_data  input  32  write data.
REQ-007 SHALL have, for N in {0,1}, port i_mN_wren  input  1  1 = write, 0 = read.
REQ-008 SHALL have, for N in {0,1}, port i_mN_mask  input  4  byte-enable.
REQ-009 SHALL have, for N in {0,1}, port o_mN_gnt  output  1  the access is issued downstream this cycle.
REQ-010 SHALL have, for N in {0,1}, port o_mN_rvalid  output  1  read data for master N is valid this cycle.
REQ-011 SHALL have, for N in {0,1}, port o_mN_rdata  output  32  read data.
REQ-012 SHALL have downstream ports o_addr (output, 30), o_data (output, 32), o_wren (output, 1), o_mask (output, 4) and i_data (input, 32), connecting to the memory crossbar.

Function
REQ-013 SHALL hold state IDLE, OWN0 or OWN1, plus an 8-bit burst counter CNT and a 1-bit LAST (the master granted most recently).
REQ-014 SHALL assert at most one o_mN_gnt per cycle; grants SHALL be combinational from the current requests and registered state.
REQ-015 SHALL, when o_mN_gnt=1, drive o_addr, o_data, o_wren and o_mask from master N's inputs in the same cycle.
REQ-016 SHALL, when no grant is asserted, drive o_wren=0, o_addr=0, o_data=0 and o_mask=0.
REQ-017 SHALL, in IDLE: with one request, grant that master; with both requests, grant the master not equal to LAST; with no request, grant nothing and stay in IDLE.
REQ-018 SHALL, in OWNx: grant x again if i_mx_req=1 and (CNT<MAX_BURST or the other master's req=0).
REQ-019 SHALL, in OWNx when REQ-018 does not grant x, grant the other master if it requests; otherwise grant nothing and go to IDLE.
REQ-020 SHALL go to OWNy after every grant to master y, and SHALL set LAST=y.
REQ-021 SHALL set CNT=1 when the grant changes owner or comes from IDLE; SHALL increment CNT on each repeat grant to the same owner, saturating at MAX_BURST.
REQ-022 SHALL, when the owner drops req in the same cycle the other raises req, grant the other master in that same cycle (no idle bubble).
REQ-023 SHALL, with MAX_BURST=1 and both masters requesting continuously, alternate grants every cycle.
REQ-024 SHALL, for a granted read (wren=0), assert o_mN_rvalid exactly one cycle after the grant, for one cycle, for that master only.
REQ-025 SHALL, for a granted write, never assert rvalid.
REQ-026 SHALL drive o_m0_rdata and o_m1_rdata equal to i_data in every cycle; rvalid qualifies them.
REQ-027 SHALL keep a read return and a new grant in the same cycle independent: back-to-back reads return one result per cycle in grant order.
REQ-028 SHALL require requesters to hold addr/data/wren/mask stable while req=1 and gnt=0; the arbiter SHALL sample them only in the granted cycle.

Reset
REQ-029 SHALL, while rst_n=0 at a clock edge, set state=IDLE, CNT=0 and LAST=1 (so master 0 wins the first tie) and clear both rvalid registers.
REQ-030 SHALL suppress all grants and drive the REQ-016 idle values during any cycle in which rst_n=0.
REQ-031 SHALL discard a pending rvalid when reset is asserted mid-operation; no rvalid SHALL appear in the cycle after reset.

Verification
REQ-032 Reset release, both req=1 from the first cycle -> m0 granted first; with MAX_BURST=4, pattern 0,0,0,0,1,1,1,1,0...
REQ-033 Only m1 requests for 10 cycles -> m1 granted all 10 cycles despite CNT saturating at 4; m0_gnt stays 0.
REQ-034 m0 read of addr 0x10 granted at cycle T with memory returning 0xDEADBEEF -> o_m0_rvalid=1 at T+1 with o_m0_rdata=0xDEADBEEF; o_m1_rvalid=0.
REQ-035 m0 owner drops req at cycle T while m1 raises req at T -> o_m1_gnt=1 at T with o_addr=m1 addr; no idle cycle.
REQ-036 MAX_BURST=1, both requesting, writes with mask 4'b0011 -> gnt alternates every cycle, o_wren=1, o_mask=4'b0011, no rvalid ever.
REQ-037 rst_n=0 in the cycle after a granted read -> no rvalid asserted, state IDLE, next tie granted to m0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master burst-limited arbiter onto one memory port.
// Grants are combinational; read returns are flagged one cycle after the grant.
module mem_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_m0_req,
  input  logic [29:0] i_m0_addr,
  input  logic [31:0] i_m0_data,
  input  logic        i_m0_wren,
  input  logic [3:0]  i_m0_mask,
  output logic        o_m0_gnt,
  output logic        o_m0_rvalid,
  output logic [31:0] o_m0_rdata,
  input  logic        i_m1_req,
  input  logic [29:0] i_m1_addr,
  input  logic [31:0] i_m1_data,
  input  logic        i_m1_wren,
  input  logic [3:0]  i_m1_mask,
  output logic        o_m1_gnt,
  output logic        o_m1_rvalid,
  output logic [31:0] o_m1_rdata,
  output logic [29:0] o_addr,
  output logic [31:0] o_data,
  output logic        o_wren,
  output logic [3:0]  o_mask,
  input  logic [31:0] i_data
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  localparam logic [7:0] MB = 8'(MAX_BURST);
  state_t      r_state, w_next;
  logic [7:0]  r_cnt, w_cnt;
  logic        r_last, w_last;
  logic        r_rv0, r_rv1;
  logic        w_g0, w_g1, w_same;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
      r_last  <= 1'b1;
      r_rv0   <= 1'b0;
      r_rv1   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_last  <= w_last;
      r_rv0   <= w_g0 & ~i_m0_wren;
      r_rv1   <= w_g1 & ~i_m1_wren;
    end
  end
  // the current owner keeps the port until its burst quota runs out while the other waits
  always_comb begin
    w_g0 = 1'b0;
    w_g1 = 1'b0;
    if (rst_n)
      case (r_state)
        IDLE: begin
          w_g0 = i_m0_req & (~i_m1_req | r_last);
          w_g1 = i_m1_req & ~w_g0;
        end
        OWN0: begin
          w_g0 = i_m0_req & ((r_cnt < MB) | ~i_m1_req);
          w_g1 = i_m1_req & ~w_g0;
        end
        OWN1: begin
          w_g1 = i_m1_req & ((r_cnt < MB) | ~i_m0_req);
          w_g0 = i_m0_req & ~w_g1;
        end
        default: ;
      endcase
    w_same = (w_g0 & (r_state == OWN0)) | (w_g1 & (r_state == OWN1));
    w_next = w_g0 ? OWN0 : w_g1 ? OWN1 : IDLE;
    w_last = w_g0 ? 1'b0 : w_g1 ? 1'b1 : r_last;
    w_cnt  = !(w_g0 | w_g1) ? r_cnt : !w_same ? 8'd1 : (r_cnt < MB) ? r_cnt + 8'd1 : r_cnt;
  end
  assign o_m0_gnt    = w_g0;
  assign o_m1_gnt    = w_g1;
  assign o_addr      = w_g0 ? i_m0_addr : w_g1 ? i_m1_addr : 30'd0;
  assign o_data      = w_g0 ? i_m0_data : w_g1 ? i_m1_data : 32'd0;
  assign o_wren      = w_g0 ? i_m0_wren : w_g1 ? i_m1_wren : 1'b0;
  assign o_mask      = w_g0 ? i_m0_mask : w_g1 ? i_m1_mask : 4'd0;
  assign o_m0_rvalid = r_rv0 & rst_n;
  assign o_m1_rvalid = r_rv1 & rst_n;
  assign o_m0_rdata  = i_data;
  assign o_m1_rdata  = i_data;
endmodule
